// File: rtl/axis_pkt_source.sv
// rtl/axis_pkt_source.sv - 8-bit AXI-Stream style burst packet source (optional checksum beat: AXIS_PKT_CSUM_EN)
module axis_pkt_source #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       pkt_len,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [7:0]       seed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkts_sent,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

`ifdef AXIS_PKT_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_CSUM} state_t;
`else
    localparam bit CSUM_EN = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`endif

    state_t state_q, state_d;

    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] ps_q, ps_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_q, beat_d;
    logic [7:0]       pay_q, pay_d;
    logic [7:0]       csum_q, csum_d;
    logic [15:0]      gap_q, gap_d;

    logic xfer;
    logic start_ok;
    logic beat_last;
    logic pkt_end;
    logic last_pkt;
    logic gap_end;

    // The first beat of a packet carries last only for single-beat packets without a checksum beat.
    function automatic logic first_last(input logic [7:0] len);
        return !CSUM_EN && (len == 8'd1);
    endfunction

    assign xfer      = valid_q && m_ready;
    assign start_ok  = start && (pkt_len != 8'd0) && (num_pkts != '0);
    assign beat_last = (beat_q == len_q);
    assign last_pkt  = ((ps_q + CNT_W'(1)) == num_q);
    assign gap_end   = (gap_q == 16'(GAP_CYCLES - 1));

`ifdef AXIS_PKT_CSUM_EN
    assign pkt_end = (state_q == S_CSUM) && xfer;
`else
    assign pkt_end = (state_q == S_SEND) && xfer && beat_last;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_SEND;
`ifdef AXIS_PKT_CSUM_EN
            S_SEND: if (xfer && beat_last) state_d = S_CSUM;
            S_CSUM: state_d = S_CSUM;
`else
            S_SEND: state_d = S_SEND;
`endif
            S_GAP:  if (gap_end) state_d = S_SEND;
            default: state_d = S_IDLE;
        endcase
        if (pkt_end) begin
            if (last_pkt) begin
                state_d = S_IDLE;
            end else if (GAP_CYCLES == 0) begin
                state_d = S_SEND;
            end else begin
                state_d = S_GAP;
            end
        end
    end

    // Next values of the registered outputs and the datapath counters.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ps_d    = ps_q;
        num_d   = num_q;
        len_d   = len_q;
        beat_d  = beat_q;
        pay_d   = pay_q;
        csum_d  = csum_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    len_d   = pkt_len;
                    num_d   = num_pkts;
                    ps_d    = '0;
                    data_d  = seed;
                    pay_d   = seed;
                    valid_d = 1'b1;
                    last_d  = first_last(pkt_len);
                    beat_d  = 8'd1;
                    csum_d  = 8'd0;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    pay_d  = data_q + 8'd1;
                    csum_d = csum_q ^ data_q;
                    if (beat_last) begin
                        if (CSUM_EN) begin
                            data_d = csum_q ^ data_q;
                            last_d = 1'b1;
                        end
                    end else begin
                        data_d = data_q + 8'd1;
                        beat_d = beat_q + 8'd1;
                        last_d = !CSUM_EN && ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    valid_d = 1'b1;
                    data_d  = pay_q;
                    beat_d  = 8'd1;
                    last_d  = first_last(len_q);
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
            end
        endcase

        // Packet boundary: count it, then finish the burst, chain the next packet, or pause.
        if (pkt_end) begin
            ps_d   = ps_q + CNT_W'(1);
            csum_d = 8'd0;
            beat_d = 8'd1;
            if (last_pkt) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
                valid_d = 1'b1;
                data_d  = pay_d;
                last_d  = first_last(len_q);
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                gap_d   = 16'd0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Output and datapath registers; reset clears everything and aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ps_q    <= '0;
            num_q   <= '0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            pay_q   <= 8'd0;
            csum_q  <= 8'd0;
            gap_q   <= 16'd0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ps_q    <= ps_d;
            num_q   <= num_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            pay_q   <= pay_d;
            csum_q  <= csum_d;
            gap_q   <= gap_d;
        end
    end

    assign m_data    = data_q;
    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkts_sent = ps_q;

endmodule

// File: tb/tb_axis_pkt_source.sv
// tb/tb_axis_pkt_source.sv - table-driven bench for axis_pkt_source
module tb_axis_pkt_source;

`ifdef AXIS_PKT_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, m_ready;
    logic [7:0] pkt_len, num_pkts, seed;
    logic       busy, done, m_valid, m_last;
    logic [7:0] pkts_sent, m_data;

    int n_vec = 0;
    int n_err = 0;

    axis_pkt_source #(.GAP_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len),
        .num_pkts(num_pkts), .seed(seed), .busy(busy), .done(done),
        .pkts_sent(pkts_sent), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] len;
        logic [7:0] num;
        logic [7:0] seed;
        logic       rdy;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       busy;
        logic       done;
        logic [7:0] ps;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic [7:0] l, input logic [7:0] n,
                       input logic [7:0] sd, input logic v, input logic [7:0] d, input logic la,
                       input logic b, input logic dn, input logic [7:0] p);
        vec_t x;
        x.rst = r; x.start = s; x.len = l; x.num = n; x.seed = sd; x.rdy = 1'b1;
        x.valid = v; x.data = d; x.last = la; x.busy = b; x.done = dn; x.ps = p;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; m_ready = 1'b1;
        pkt_len = 8'd0; num_pkts = 8'd0; seed = 8'd0;

        // rst, start, len, num, seed | valid, data, last, busy, done, pkts_sent
        add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
`ifndef AXIS_PKT_CSUM_EN
        add(1, 1, 4, 1, 8'h10, 1, 8'h10, 0, 1, 0, 0);
        add(1, 0, 4, 1, 8'h10, 1, 8'h11, 0, 1, 0, 0);
        add(1, 0, 4, 1, 8'h10, 1, 8'h12, 0, 1, 0, 0);
        add(1, 0, 4, 1, 8'h10, 1, 8'h13, 1, 1, 0, 0);
        add(1, 0, 4, 1, 8'h10, 0, 8'h00, 0, 0, 1, 1);
        add(1, 0, 4, 1, 8'h10, 0, 8'h00, 0, 0, 0, 1);
        add(1, 1, 3, 2, 8'hFE, 1, 8'hFE, 0, 1, 0, 0);
        add(1, 0, 3, 2, 8'hFE, 1, 8'hFF, 0, 1, 0, 0);
        add(1, 0, 3, 2, 8'hFE, 1, 8'h00, 1, 1, 0, 0);
        add(1, 0, 3, 2, 8'hFE, 0, 8'h00, 0, 1, 0, 1);
        add(1, 0, 3, 2, 8'hFE, 0, 8'h00, 0, 1, 0, 1);
        add(1, 0, 3, 2, 8'hFE, 1, 8'h01, 0, 1, 0, 1);
        add(1, 0, 3, 2, 8'hFE, 1, 8'h02, 0, 1, 0, 1);
        add(1, 0, 3, 2, 8'hFE, 1, 8'h03, 1, 1, 0, 1);
        add(1, 0, 3, 2, 8'hFE, 0, 8'h00, 0, 0, 1, 2);
        add(1, 1, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, 2);
        add(1, 1, 3, 0, 8'h55, 0, 8'h00, 0, 0, 0, 2);
        add(1, 0, 3, 0, 8'h55, 0, 8'h00, 0, 0, 0, 2);
        add(1, 1, 1, 2, 8'h7F, 1, 8'h7F, 1, 1, 0, 0);
        add(1, 0, 1, 2, 8'h7F, 0, 8'h00, 0, 1, 0, 1);
        add(1, 0, 1, 2, 8'h7F, 0, 8'h00, 0, 1, 0, 1);
        add(1, 0, 1, 2, 8'h7F, 1, 8'h80, 1, 1, 0, 1);
        add(1, 0, 1, 2, 8'h7F, 0, 8'h00, 0, 0, 1, 2);
`else
        add(1, 1, 3, 1, 8'h01, 1, 8'h01, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h01, 1, 8'h02, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h01, 1, 8'h03, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h01, 1, 8'h00, 1, 1, 0, 0);
        add(1, 0, 3, 1, 8'h01, 0, 8'h00, 0, 0, 1, 1);
        add(1, 1, 3, 1, 8'h05, 1, 8'h05, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h05, 1, 8'h06, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h05, 1, 8'h07, 0, 1, 0, 0);
        add(1, 0, 3, 1, 8'h05, 1, 8'h04, 1, 1, 0, 0);
        add(1, 0, 3, 1, 8'h05, 0, 8'h00, 0, 0, 1, 1);
        add(1, 1, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, 1);
        add(1, 1, 3, 0, 8'h55, 0, 8'h00, 0, 0, 0, 1);
`endif

        foreach (vq[i]) begin
            rst = vq[i].rst; start = vq[i].start; pkt_len = vq[i].len;
            num_pkts = vq[i].num; seed = vq[i].seed; m_ready = vq[i].rdy;
            tick();
            chk("m_valid", i, 32'(m_valid), 32'(vq[i].valid));
            if (vq[i].valid || !vq[i].rst) chk("m_data", i, 32'(m_data), 32'(vq[i].data));
            chk("m_last", i, 32'(m_last), 32'(vq[i].last));
            chk("busy", i, 32'(busy), 32'(vq[i].busy));
            chk("done", i, 32'(done), 32'(vq[i].done));
            chk("pkts_sent", i, 32'(pkts_sent), 32'(vq[i].ps));
        end
        start = 1'b0;

        // Backpressure: ready 1,1,1,0,0 repeating, plus an ignored start mid-burst.
        begin
            bit   bp[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            int   n = 0;
            int   cyc = 0;
            int   total = 8 + CS;
            logic [7:0] acc = 8'h00;
            logic [7:0] ed;
            logic prev_stall = 1'b0;
            start = 1'b1; pkt_len = 8'd8; num_pkts = 8'd1; seed = 8'h20; m_ready = 1'b0;
            tick();
            while (n < total && cyc < 200) begin
                m_ready = bp[cyc % 5];
                if (cyc == 3) begin
                    start = 1'b1; pkt_len = 8'd2; num_pkts = 8'd3; seed = 8'h99;
                end else begin
                    start = 1'b0;
                end
                if (prev_stall) chk("bp_valid_hold", n, 32'(m_valid), 32'd1);
                if (m_valid) begin
                    ed = (n < 8) ? 8'(8'h20 + n) : acc;
                    chk("bp_data", n, 32'(m_data), 32'(ed));
                    chk("bp_last", n, 32'(m_last), 32'(n == total - 1));
                    if (m_ready) begin
                        if (n < 8) acc = acc ^ ed;
                        n++;
                    end
                end
                prev_stall = m_valid && !m_ready;
                tick();
                cyc++;
            end
            start = 1'b0; m_ready = 1'b1;
            chk("bp_transfers", cyc, 32'(n), 32'(total));
            chk("bp_done", cyc, 32'(done), 32'd1);
            chk("bp_pkts_sent", cyc, 32'(pkts_sent), 32'd1);
            chk("bp_busy", cyc, 32'(busy), 32'd0);
            tick();
            chk("bp_no_restart", cyc, 32'(busy), 32'd0);
        end

        // Reset abort during beat 2, then a clean restart.
        begin
            int k = 0;
            start = 1'b1; pkt_len = 8'd5; num_pkts = 8'd1; seed = 8'h30; m_ready = 1'b1;
            tick();
            start = 1'b0;
            chk("ra_beat1", 0, 32'(m_data), 32'h30);
            tick();
            chk("ra_beat2", 0, 32'(m_data), 32'h31);
            rst = 1'b0;
            tick();
            chk("ra_valid", 0, 32'(m_valid), 32'd0);
            chk("ra_data", 0, 32'(m_data), 32'd0);
            chk("ra_last", 0, 32'(m_last), 32'd0);
            chk("ra_busy", 0, 32'(busy), 32'd0);
            chk("ra_done", 0, 32'(done), 32'd0);
            chk("ra_ps", 0, 32'(pkts_sent), 32'd0);
            rst = 1'b1;
            tick();
            chk("ra_idle_done", 0, 32'(done), 32'd0);
            start = 1'b1; pkt_len = 8'd2; num_pkts = 8'd1; seed = 8'h40;
            tick();
            start = 1'b0;
            chk("rs_valid", 0, 32'(m_valid), 32'd1);
            chk("rs_data0", 0, 32'(m_data), 32'h40);
            tick();
            chk("rs_data1", 0, 32'(m_data), 32'h41);
            chk("rs_last1", 0, 32'(m_last), 32'(CS == 0));
            while (!done && k < 6) begin
                tick();
                k++;
            end
            chk("rs_done", k, 32'(done), 32'd1);
            chk("rs_ps", k, 32'(pkts_sent), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
